binomial_filter_checker: RTL and testbench

//  Self-checking response end for the binomial filter bench: receives the stimulus sample stream and the
//  DUT output, recomputes the normalised binomial-weighted sum, aligns it to DUT latency, compares.

---
 rtl/binomial_pkg.sv | 12 +
 rtl/binomial_filter_checker_if.sv | 18 +
 rtl/binomial_ref_model.sv | 55 +++++
 rtl/binomial_filter_checker.sv | 74 +++++++
 tb/tb_binomial_filter_checker.sv | 139 +++++++++++++
 5 files changed

// File: rtl/binomial_pkg.sv
// binomial_pkg: shared FSM state type and binomial weight helpers for the filter checker.
package binomial_pkg;
    typedef enum logic [1:0] {FILL, CHECK, FAIL} state_e;
    function automatic int binom(int n, int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction
    function automatic int accw(int dw, int n);
        return dw + n - 1;
    endfunction
endpackage

// File: rtl/binomial_filter_checker_if.sv
// binomial_filter_checker_if: stimulus/response bundle between the test top and the checker.
// BINOMIAL_CHECK_CAPTURE_EN adds the first-error capture fields.
interface binomial_filter_checker_if #(parameter int DW = 8, parameter int CW = 16);
    logic [DW-1:0] inp, outp, expected;
    logic          checking, match, fail;
    logic [CW-1:0] mismatch_cnt, sample_cnt;
`ifdef BINOMIAL_CHECK_CAPTURE_EN
    logic [CW-1:0] first_err_idx;
    logic [DW-1:0] first_err_exp, first_err_act;
    modport master (output inp, outp, input expected, checking, match, fail, mismatch_cnt, sample_cnt,
                    first_err_idx, first_err_exp, first_err_act);
    modport slave  (input inp, outp, output expected, checking, match, fail, mismatch_cnt, sample_cnt,
                    first_err_idx, first_err_exp, first_err_act);
`else
    modport master (output inp, outp, input expected, checking, match, fail, mismatch_cnt, sample_cnt);
    modport slave  (input inp, outp, output expected, checking, match, fail, mismatch_cnt, sample_cnt);
`endif
endinterface

// File: rtl/binomial_ref_model.sv
// binomial_ref_model: sample history, normalised binomial-weighted sum and latency alignment line.
module binomial_ref_model
    import binomial_pkg::*;
#(
    parameter int DW  = 8,
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inp_i,
    output logic [DW-1:0] ref_o,
    output logic          ref_valid_o
);
    localparam int ACCW  = accw(DW, N);
    localparam int PRIME = N - 1 + LAT;
    localparam int PW    = $clog2(PRIME + 1);
    logic [N-2:0][DW-1:0] hist_q;
    logic [PW-1:0]        cnt_q;
    logic [ACCW-1:0]      acc;
    logic [DW-1:0]        ref_now;
    // the current sample is weighted straight from the input so its reference is ready at this edge
    always_comb begin
        acc = ACCW'(inp_i) * ACCW'(binom(N - 1, 0));
        for (int k = 1; k < N; k++) acc = acc + ACCW'(hist_q[k-1]) * ACCW'(binom(N - 1, k));
    end
    assign ref_now     = DW'(acc >> (N - 1));
    assign ref_valid_o = cnt_q == PW'(PRIME);
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q[0] <= inp_i;
            for (int k = 1; k < N - 1; k++) hist_q[k] <= hist_q[k-1];
            if (!ref_valid_o) cnt_q <= cnt_q + PW'(1);
        end
    end
    generate
        if (LAT == 0) begin : g_direct
            assign ref_o = ref_now;
        end else begin : g_delay
            logic [LAT-1:0][DW-1:0] dl_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dl_q <= '0;
                end else begin
                    dl_q[0] <= ref_now;
                    for (int k = 1; k < LAT; k++) dl_q[k] <= dl_q[k-1];
                end
            end
            assign ref_o = dl_q[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/binomial_filter_checker.sv
// binomial_filter_checker: compares DUT output against the aligned binomial reference, keeps counts and a sticky fail.
// BINOMIAL_CHECK_CAPTURE_EN adds first-error index/expected/actual capture.
module binomial_filter_checker
    import binomial_pkg::*;
#(
    parameter int DW  = 8,
    parameter int N   = 4,
    parameter int LAT = 1,
    parameter int CW  = 16
) (
    input logic                      clk,
    input logic                      rst,
    binomial_filter_checker_if.slave bus
);
    state_e        state_q;
    logic [DW-1:0] expected_q, ref_a;
    logic          match_q, fail_q, ref_valid, live, mis;
    logic [CW-1:0] mcnt_q, scnt_q;
`ifdef BINOMIAL_CHECK_CAPTURE_EN
    logic [CW-1:0] fe_idx_q;
    logic [DW-1:0] fe_exp_q, fe_act_q;
`endif
    binomial_ref_model #(.DW(DW), .N(N), .LAT(LAT)) u_ref (
        .clk(clk), .rst(rst), .inp_i(bus.inp), .ref_o(ref_a), .ref_valid_o(ref_valid)
    );
    assign live = state_q != FILL || ref_valid;
    assign mis  = bus.outp != ref_a;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            expected_q <= '0;
            match_q    <= 1'b0;
            fail_q     <= 1'b0;
            mcnt_q     <= '0;
            scnt_q     <= '0;
`ifdef BINOMIAL_CHECK_CAPTURE_EN
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
`endif
        end else begin
            if (scnt_q != '1) scnt_q <= scnt_q + CW'(1);
            if (live) begin
                expected_q <= ref_a;
                match_q    <= !mis;
                if (mis) begin
                    state_q <= FAIL;
                    fail_q  <= 1'b1;
                    if (mcnt_q != '1) mcnt_q <= mcnt_q + CW'(1);
`ifdef BINOMIAL_CHECK_CAPTURE_EN
                    if (!fail_q) begin
                        fe_idx_q <= scnt_q;
                        fe_exp_q <= ref_a;
                        fe_act_q <= bus.outp;
                    end
`endif
                end else if (state_q == FILL) begin
                    state_q <= CHECK;
                end
            end
        end
    end
    assign bus.expected     = expected_q;
    assign bus.checking     = state_q != FILL;
    assign bus.match        = match_q;
    assign bus.fail         = fail_q;
    assign bus.mismatch_cnt = mcnt_q;
    assign bus.sample_cnt   = scnt_q;
`ifdef BINOMIAL_CHECK_CAPTURE_EN
    assign bus.first_err_idx = fe_idx_q;
    assign bus.first_err_exp = fe_exp_q;
    assign bus.first_err_act = fe_act_q;
`endif
endmodule

// File: tb/tb_binomial_filter_checker.sv
// tb_binomial_filter_checker: directed ramp/wrap/error/reset runs on N=4 LAT=1, plus LAT=0 and CW=4 instances.
module tb_binomial_filter_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    binomial_filter_checker_if #(.DW(8), .CW(16)) bm ();
    binomial_filter_checker_if #(.DW(8), .CW(16)) bz ();
    binomial_filter_checker_if #(.DW(8), .CW(4))  bs ();
    binomial_filter_checker #(.DW(8), .N(4), .LAT(1), .CW(16)) dut   (.clk(clk), .rst(rst), .bus(bm));
    binomial_filter_checker #(.DW(8), .N(4), .LAT(0), .CW(16)) dut_z (.clk(clk), .rst(rst), .bus(bz));
    binomial_filter_checker #(.DW(8), .N(4), .LAT(1), .CW(4))  dut_s (.clk(clk), .rst(rst), .bus(bs));
    int nassert = 0;
    int nfail = 0;
    int xs [0:299];
    logic [7:0] zo [0:11];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] mref(input int t);
        int s = xs[t] + 3 * xs[t-1] + 3 * xs[t-2] + xs[t-3];
        return 8'(s >> 3);
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        zo = '{8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 8'd200, 8'd206, 8'd227, 8'd248, 8'd255, 8'd255};
        rst = 1'b1;
        bm.inp = '0; bm.outp = '0; bz.inp = '0; bz.outp = '0; bs.inp = '0; bs.outp = '0;
        step();
        step();
        chk("rst_expected", 32'(bm.expected), 0);
        chk("rst_checking", 32'(bm.checking), 0);
        chk("rst_match", 32'(bm.match), 0);
        chk("rst_mcnt", 32'(bm.mismatch_cnt), 0);
        chk("rst_scnt", 32'(bm.sample_cnt), 0);
        chk("rst_fail", 32'(bm.fail), 0);
`ifdef BINOMIAL_CHECK_CAPTURE_EN
        chk("rst_fe_idx", 32'(bm.first_err_idx), 0);
`endif
        rst = 1'b0;
        for (int t = 0; t < 260; t++) begin
            xs[t] = t % 256;
            bm.inp  = 8'(t);
            bm.outp = (t >= 4) ? mref(t - 1) : 8'd0;
            if (t == 10) bm.outp = bm.outp + 8'd1;
            bs.inp  = 8'(t);
            bs.outp = 8'd0;
            bz.inp  = (t < 7) ? 8'd200 : 8'd255;
            bz.outp = (t < 12) ? zo[t] : 8'd255;
            step();
            if (t == 3) begin
                chk("fill_checking", 32'(bm.checking), 0);
                chk("fill_match", 32'(bm.match), 0);
                chk("fill_expected", 32'(bm.expected), 0);
                chk("s_mcnt_fill", 32'(bs.mismatch_cnt), 0);
            end
            if (t == 4) begin
                chk("first_checking", 32'(bm.checking), 1);
                chk("first_expected", 32'(bm.expected), 1);
                chk("s_first_mis", 32'(bs.mismatch_cnt), 1);
                chk("s_fail", 32'(bs.fail), 1);
            end
            if (t >= 4 && t != 10) chk("ramp_match", 32'(bm.match), 1);
            if (t == 9) begin
                chk("pre_err_fail", 32'(bm.fail), 0);
                chk("pre_err_mcnt", 32'(bm.mismatch_cnt), 0);
            end
            if (t == 10) begin
                chk("err_match", 32'(bm.match), 0);
                chk("err_mcnt", 32'(bm.mismatch_cnt), 1);
                chk("err_fail", 32'(bm.fail), 1);
                chk("err_expected", 32'(bm.expected), 7);
`ifdef BINOMIAL_CHECK_CAPTURE_EN
                chk("fe_idx", 32'(bm.first_err_idx), 10);
                chk("fe_exp", 32'(bm.first_err_exp), 7);
                chk("fe_act", 32'(bm.first_err_act), 8);
`endif
            end
            if (t == 11) begin
                chk("post_err_fail", 32'(bm.fail), 1);
                chk("post_err_mcnt", 32'(bm.mismatch_cnt), 1);
            end
            if (t == 2) chk("z_fill_checking", 32'(bz.checking), 0);
            if (t >= 3 && t < 12) begin
                chk("z_match", 32'(bz.match), 1);
                chk("z_expected", 32'(bz.expected), 32'(zo[t]));
            end
            if (t == 11) chk("z_mcnt", 32'(bz.mismatch_cnt), 0);
            if (t == 13) chk("s_scnt_14", 32'(bs.sample_cnt), 14);
            if (t == 17) chk("s_mcnt_14", 32'(bs.mismatch_cnt), 14);
            if (t == 29) begin
                chk("s_mcnt_sat", 32'(bs.mismatch_cnt), 15);
                chk("s_scnt_sat", 32'(bs.sample_cnt), 15);
            end
            if (t == 258) chk("wrap_expected", 32'(bm.expected), 127);
            if (t == 259) begin
                chk("final_scnt", 32'(bm.sample_cnt), 260);
                chk("final_mcnt", 32'(bm.mismatch_cnt), 1);
                chk("final_fail", 32'(bm.fail), 1);
`ifdef BINOMIAL_CHECK_CAPTURE_EN
                chk("fe_frozen", 32'(bm.first_err_idx), 10);
`endif
            end
        end
        rst = 1'b1;
        step();
        chk("mid_rst_expected", 32'(bm.expected), 0);
        chk("mid_rst_checking", 32'(bm.checking), 0);
        chk("mid_rst_match", 32'(bm.match), 0);
        chk("mid_rst_mcnt", 32'(bm.mismatch_cnt), 0);
        chk("mid_rst_scnt", 32'(bm.sample_cnt), 0);
        chk("mid_rst_fail", 32'(bm.fail), 0);
`ifdef BINOMIAL_CHECK_CAPTURE_EN
        chk("mid_rst_fe_act", 32'(bm.first_err_act), 0);
`endif
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            xs[t] = t + 50;
            bm.inp  = 8'(t + 50);
            bm.outp = (t >= 4) ? mref(t - 1) : 8'd0;
            step();
            if (t <= 3) chk("refill_checking", 32'(bm.checking), 0);
            if (t >= 4) begin
                chk("recheck_checking", 32'(bm.checking), 1);
                chk("recheck_match", 32'(bm.match), 1);
            end
        end
        chk("recheck_expected", 32'(bm.expected), 52);
        chk("recheck_fail", 32'(bm.fail), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
